// File: rtl/core_pkg.sv
// Shared types for the ARM core execute path:
// condition codes and NZCV flag bit positions.
package core_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator:
// tests a 4-bit cond field against NZCV.
module cond_check
  import core_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  always_comb begin
    n = flags_i[FLAG_N];
    z = flags_i[FLAG_Z];
    c = flags_i[FLAG_C];
    v = flags_i[FLAG_V];
    cond_ex_o = 1'b0;
    unique case (cond_t'(cond_i))
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      COND_NV: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV register,
// write-enable gating and exec/skip counters.
module cond_logic
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             en,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  output logic             cond_ex,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic [3:0]       flags,
  output logic             carry,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             go;

  cond_check u_check (
    .cond_i    (cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  // Enables drop combinationally while reset is held.
  assign go = en & cond_ex & n_reset;

  always_comb begin
    flags_d = flags_q;
    exec_d  = exec_q;
    skip_d  = skip_q;
    if (go && flag_w[1]) begin
      flags_d[FLAG_N] = alu_flags[FLAG_N];
      flags_d[FLAG_Z] = alu_flags[FLAG_Z];
    end
    if (go && flag_w[0]) begin
      flags_d[FLAG_C] = alu_flags[FLAG_C];
      flags_d[FLAG_V] = alu_flags[FLAG_V];
    end
    if (en) begin
      if (cond_ex) exec_d = exec_q + 1'b1;
      else         skip_d = skip_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      flags_q <= '0;
      exec_q  <= '0;
      skip_q  <= '0;
    end else begin
      flags_q <= flags_d;
      exec_q  <= exec_d;
      skip_q  <= skip_d;
    end
  end

  assign pc_src    = pcs & go;
  assign reg_write = reg_w & ~no_write & go;
  assign mem_write = mem_w & go;
  assign flags     = flags_q;
  assign carry     = flags_q[FLAG_C];
  assign exec_cnt  = exec_q;
  assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed scoreboard bench for cond_logic
// (CNT_W=4 so counter wrap is reachable).
module tb_cond_logic;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         en;
  logic [3:0]   cond;
  logic [3:0]   alu_flags;
  logic [1:0]   flag_w;
  logic         pcs, reg_w, mem_w, no_write;
  logic         cond_ex, pc_src, reg_write, mem_write;
  logic [3:0]   flags;
  logic         carry;
  logic [W-1:0] exec_cnt, skip_cnt;

  cond_logic #(.CNT_W(W)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .en        (en),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .cond_ex   (cond_ex),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .flags     (flags),
    .carry     (carry),
    .exec_cnt  (exec_cnt),
    .skip_cnt  (skip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic         cex, pc, rw, mw;
    logic [3:0]   fl;
    logic [W-1:0] ex, sk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] m_ex = '0;
  logic [W-1:0] m_sk = '0;

  task automatic chk(string tag, string f, logic [7:0] act, logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s got=%h want=%h", tag, f, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "cond_ex",   {7'd0, cond_ex},   {7'd0, e.cex});
      chk(e.tag, "pc_src",    {7'd0, pc_src},    {7'd0, e.pc});
      chk(e.tag, "reg_write", {7'd0, reg_write}, {7'd0, e.rw});
      chk(e.tag, "mem_write", {7'd0, mem_write}, {7'd0, e.mw});
      chk(e.tag, "flags",     {4'd0, flags},     {4'd0, e.fl});
      chk(e.tag, "carry",     {7'd0, carry},     {7'd0, e.fl[1]});
      chk(e.tag, "exec_cnt",  {4'd0, exec_cnt},  {4'd0, e.ex});
      chk(e.tag, "skip_cnt",  {4'd0, skip_cnt},  {4'd0, e.sk});
    end
  end

  // One cycle: drive controls, queue hand-computed expectation
  // (fl = flags held before this edge), then step counter model.
  task automatic step(
    string tag, logic rst_n, logic e, logic [3:0] c,
    logic [3:0] alu, logic [1:0] fw,
    logic p, logic r, logic m, logic nw,
    logic xcex, logic xpc, logic xrw, logic xmw, logic [3:0] xfl
  );
    exp_t x;
    @(posedge clk);
    #1;
    n_reset = rst_n; en = e; cond = c;
    alu_flags = alu; flag_w = fw;
    pcs = p; reg_w = r; mem_w = m; no_write = nw;
    x.tag = tag; x.cex = xcex; x.pc = xpc; x.rw = xrw; x.mw = xmw;
    x.fl = xfl; x.ex = m_ex; x.sk = m_sk;
    exp_q.push_back(x);
    if (!rst_n) begin
      m_ex = '0; m_sk = '0;
    end else if (e) begin
      if (xcex) m_ex = m_ex + 1'b1;
      else      m_sk = m_sk + 1'b1;
    end
  endtask

  initial begin
    n_reset = 1'b0; en = 1'b0; cond = 4'hE; alu_flags = 4'h0;
    flag_w = 2'b00; pcs = 0; reg_w = 0; mem_w = 0; no_write = 0;
    @(posedge clk);
    // reset held: cond_ex live, enables forced low
    step("rst",    0,1,4'hE,4'hF,2'b11, 1,1,1,0, 1,0,0,0, 4'h0);
    step("al_rw",  1,1,4'hE,4'h0,2'b00, 0,1,0,0, 1,0,1,0, 4'h0);
    step("fw_nz",  1,1,4'hE,4'hF,2'b10, 0,0,0,0, 1,0,0,0, 4'h0);
    step("fw_cv0", 1,1,4'hE,4'h0,2'b01, 0,0,0,0, 1,0,0,0, 4'hC);
    step("fw_cv1", 1,1,4'hE,4'h3,2'b01, 0,0,0,0, 1,0,0,0, 4'hC);
    step("ld_z",   1,1,4'hE,4'h4,2'b11, 0,0,1,0, 1,0,0,1, 4'hF);
    step("eq",     1,1,4'h0,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'h4);
    step("ne",     1,1,4'h1,4'h0,2'b00, 0,0,0,0, 0,0,0,0, 4'h4);
    step("ls",     1,1,4'h9,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'h4);
    step("hi",     1,1,4'h8,4'h0,2'b00, 0,0,0,0, 0,0,0,0, 4'h4);
    step("gt",     1,1,4'hC,4'h0,2'b00, 0,0,0,0, 0,0,0,0, 4'h4);
    step("le",     1,1,4'hD,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'h4);
    step("nv",     1,1,4'hF,4'hF,2'b11, 1,1,1,0, 0,0,0,0, 4'h4);
    step("ld_nv",  1,1,4'hE,4'h9,2'b11, 0,0,0,0, 1,0,0,0, 4'h4);
    step("ge",     1,1,4'hA,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'h9);
    step("lt",     1,1,4'hB,4'h0,2'b00, 0,0,0,0, 0,0,0,0, 4'h9);
    step("ld_0",   1,1,4'hE,4'h0,2'b11, 0,0,0,0, 1,0,0,0, 4'h9);
    step("gate",   1,1,4'h0,4'h4,2'b11, 1,1,1,0, 0,0,0,0, 4'h0);
    step("cmp",    1,1,4'hE,4'h0,2'b00, 0,1,0,1, 1,0,0,0, 4'h0);
    step("stall",  1,0,4'hE,4'hF,2'b11, 1,1,1,0, 1,0,0,0, 4'h0);
    step("eq_fs",  1,1,4'h0,4'hF,2'b11, 0,1,0,0, 0,0,0,0, 4'h0);
    step("subs",   1,1,4'hE,4'h6,2'b11, 0,1,0,0, 1,0,1,0, 4'h0);
    step("beq",    1,1,4'h0,4'h0,2'b00, 1,0,0,0, 1,1,0,0, 4'h6);
    for (int i = 0; i < 17; i++)
      step("wrap", 1,1,4'hE,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'h6);
    // reset must beat a simultaneous flag write and count
    step("rst_pri",0,1,4'hE,4'hF,2'b11, 1,1,1,0, 1,0,0,0, 4'h6);
    step("post",   1,1,4'hE,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'h0);
    step("post2",  1,0,4'h1,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the instruction decoder in the ARM core.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field against it.
- Gates the decoder's raw pcs/reg_w/mem_w/no_write controls into final write enables.
- Updates flags from the ALU under decoder flag_w control, supplies carry-in for ADC, and counts executed vs. skipped instructions.

Parameters:
- CNT_W, 32, width of the executed and skipped instruction counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- n_reset  input  1  synchronous, active-low reset.
- en  input  1  instruction valid / not stalled; 0 = bubble, no state change, all enables 0.
- cond  input  4  instruction bits [31:28].
- alu_flags  input  4  ALU result flags {N,Z,C,V}.
- flag_w  input  2  from decoder; [1] writes N,Z; [0] writes C,V.
- pcs  input  1  decoder: writes PC (branch or Rd=15).
- reg_w  input  1  decoder: register write.
- mem_w  input  1  decoder: memory write.
- no_write  input  1  decoder: compare op (CMP/CMN/TST/TEQ), suppresses register write.
- cond_ex  output  1  condition passed for the current instruction.
- pc_src  output  1  pcs & cond_ex & en.
- reg_write  output  1  reg_w & ~no_write & cond_ex & en.
- mem_write  output  1  mem_w & cond_ex & en.
- flags  output  4  registered {N,Z,C,V}.
- carry  output  1  registered C, used as ALU carry-in (alu_ctl 3'b100, ADC).
- exec_cnt  output  CNT_W  instructions with en & cond_ex.
- skip_cnt  output  CNT_W  instructions with en & ~cond_ex.

Behaviour:
- Reset: applies when n_reset=0 at a rising edge.
  - flags, exec_cnt and skip_cnt clear to 0; carry reads 0.
  - While n_reset=0, pc_src, reg_write and mem_write are forced 0 combinationally. cond_ex still reflects the cond input against the flag register.
- cond_ex is combinational from cond and the registered flags, with zero-cycle latency.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (unsupported; treated as never)
- Flag update at rising edge when en & cond_ex & n_reset:
  - flag_w[1]: N,Z <= alu_flags[3:2].
  - flag_w[0]: C,V <= alu_flags[1:0].
  - Each half is independent; 2'b00 leaves flags unchanged.
- Condition evaluation uses pre-update flags. A flag-setting conditional instruction tests old flags; the next instruction sees the new flags one cycle later.
- Failed condition (cond_ex=0): no flag update and all three enables 0, regardless of decoder controls.
- en=0: no flag update, no counter change, all enables 0.
- Counters: exactly one of exec_cnt/skip_cnt increments per cycle with en=1. Both wrap modulo 2^CNT_W with no saturation.
- Reset mid-stream: reset takes priority over a simultaneous flag update and counter increment.

Decomposition:
- Shared package core_pkg:
  - enum cond_t, with the 16 codes above.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_check: purely combinational (cond, flags) -> cond_ex. It is separately unit-testable across all 16 codes.
- Top level cond_logic holds the flag register, the counters and the enable gating.

Test Plan:
- Reset then AL: n_reset=0 one cycle, release. cond=1110, reg_w=1 -> flags=0000, reg_write=1, exec_cnt=0 before edge and 1 after.
- Flag write halves, all with cond=AL:
  - alu_flags=1111, flag_w=10 -> flags=1100.
  - Next: alu_flags=0000, flag_w=01 -> flags=1100 (C,V already 0).
  - Next: alu_flags=0011, flag_w=01 -> flags=1111, carry=1.
- Condition sweep: load flags=0100 (Z=1). EQ -> cond_ex=1; NE=0; LS=1; HI=0; GT=0; LE=1; 1111=0. Repeat with flags=1001 -> GE=1, LT=0.
- Gating, flags=0000: cond=EQ, pcs=1, reg_w=1, mem_w=1, flag_w=11, alu_flags=0100 -> pc_src=reg_write=mem_write=0, flags stay 0000, skip_cnt +1. CMP with cond=AL, reg_w=1, no_write=1 -> reg_write=0.
- Stall/ordering:
  - en=0 with cond=AL, flag_w=11 -> no flag change, counters unchanged, enables 0.
  - Flag-setting cond=EQ instruction with Z=0 does not update flags.
  - Back-to-back SUBS (writes Z=1) then BEQ -> BEQ sees Z=1, pc_src=1.
- Wrap/reset priority: CNT_W=4, 16 executed instructions -> exec_cnt wraps to 0. Assert n_reset=0 coincident with flag_w=11 -> flags=0000 after edge.
